// File: rtl/vga_scan_out.sv
// vga_scan_out: raster timing generator and RGB332->RGB444 pixel output stage for the text GPU.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that replaces pixel data with 8 colour bars.
module vga_scan_out #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_en,
    input  logic [7:0]  pixel_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [19:0] address,
    output logic        v_sync,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        active,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4 || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_param
            $error("vga_scan_out: PIPE_DELAY must be 0..4 and raster totals must fit 10 bits");
        end
    endgenerate

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       raw_act;
    logic       raw_hs;
    logic       raw_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // The counters themselves are the address register, so it is valid through blanking too.
    assign address = {v_cnt, h_cnt};

    assign raw_act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign raw_hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign raw_vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign v_sync  = raw_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;

`ifdef VGA_TEST_PATTERN_EN
    localparam int DW = 13;
    logic [DW-1:0] stage0;
    assign stage0 = {h_cnt, raw_act, raw_hs, raw_vs};
`else
    localparam int DW = 3;
    logic [DW-1:0] stage0;
    assign stage0 = {raw_act, raw_hs, raw_vs};
`endif

    logic [DW-1:0] dly;

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign dly = stage0;
        end else begin : g_pipe
            logic [DW-1:0] pipe [PIPE_DELAY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= '0;
                end else if (pixel_en) begin
                    pipe[0] <= stage0;
                    for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign dly = pipe[PIPE_DELAY-1];
        end
    endgenerate

    logic [7:0] pix;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
    logic [9:0] bar_idx;
    logic [7:0] bar_col;

    assign bar_idx = dly[12:3] / BAR_W;

    always_comb begin
        bar_col = 8'h00;
        case (bar_idx)
            10'd0:   bar_col = 8'hFF;
            10'd1:   bar_col = 8'hE0;
            10'd2:   bar_col = 8'h1C;
            10'd3:   bar_col = 8'h03;
            10'd4:   bar_col = 8'hFC;
            10'd5:   bar_col = 8'h1F;
            10'd6:   bar_col = 8'hE3;
            default: bar_col = 8'h00;
        endcase
    end

    assign pix = test_mode ? bar_col : pixel_data;
`else
    assign pix = pixel_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs      <= ~SYNC_ACTIVE;
            vga_vs      <= ~SYNC_ACTIVE;
            active      <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
            if (pixel_en) begin
                active <= dly[2];
                vga_hs <= dly[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vga_vs <= dly[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                if (dly[2]) begin
                    vga_r <= {pix[7:5], pix[7]};
                    vga_g <= {pix[4:2], pix[4]};
                    vga_b <= {pix[1:0], pix[1:0]};
                end else begin
                    vga_r <= '0;
                    vga_g <= '0;
                    vga_b <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Self-checking bench for vga_scan_out on a shrunken raster, against a tick-count reference model.
`timescale 1ns/1ps
module tb_vga_scan_out;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
    localparam int PD = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pixel_en = 1'b0;
    logic [7:0]  pixel_data;
    logic        test_mode = 1'b0;
    logic [19:0] address;
    logic        v_sync, vga_hs, vga_vs, active, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;

    int          errors = 0;
    int          checks = 0;
    int          n = 0;
    logic        fs_exp = 1'b0;
    int          mode = 0;
    logic [7:0]  salt = 8'h00;
    logic [7:0]  gpu_q;
    logic [36:0] obs;
    logic [36:0] exp_bus;
    logic [7:0]  bars [8] = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h00};

    vga_scan_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(PD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pixel_en(pixel_en),
        .pixel_data(pixel_data),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .address(address),
        .v_sync(v_sync),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .active(active),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Pixel memory content seen by the GPU: 0 hashed, 1 constant red, 2 address low byte.
    function automatic logic [7:0] pat(input logic [19:0] a);
        case (mode)
            0:       pat = (a[7:0] * 8'd29) ^ a[17:10] ^ salt;
            1:       pat = 8'hE0;
            default: pat = a[7:0];
        endcase
    endfunction

    // One-tick GPU read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        gpu_q <= 8'h00;
        else if (pixel_en) gpu_q <= pat(address);
    end
    assign pixel_data = gpu_q;

    assign obs = {address, v_sync, vga_hs, vga_vs, active, vga_r, vga_g, vga_b, frame_start};

    // Reference: n ticks since reset puts the scan at position n; the pins show position n-PD-1.
    task automatic compute_expected();
        int x, y, m;
        logic act, hs, vs, vsy;
        logic [7:0]  p;
        logic [11:0] rgb;
        x = n % HT;
        y = (n / HT) % VT;
        vsy = (y >= VA + VF && y < VA + VF + VS) ? 1'b0 : 1'b1;
        m = n - PD - 1;
        act = 1'b0; hs = 1'b0; vs = 1'b0; p = 8'h00;
        if (m >= 0) begin
            x = m % HT;
            y = (m / HT) % VT;
            act = (x < HA) && (y < VA);
            hs  = (x >= HA + HF) && (x < HA + HF + HS);
            vs  = (y >= VA + VF) && (y < VA + VF + VS);
            if (test_mode && act) p = bars[x / (HA / 8)];
            else                  p = pat({10'(y), 10'(x)});
        end
        rgb = act ? {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]} : 12'h000;
        exp_bus = {10'((n / HT) % VT), 10'(n % HT), vsy, ~hs, ~vs, act, rgb, fs_exp};
    endtask

    task automatic tick(input logic en);
        @(negedge clk);
        pixel_en = en;
        @(posedge clk);
        if (en) n++;
        fs_exp = en && (n > 0) && (n % FRAME == 0);
        #1;
        compute_expected();
    endtask

    task automatic do_reset();
        @(negedge clk);
        pixel_en = 1'b0;
        rst_n = 1'b0;
        n = 0;
        fs_exp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compute_expected();
    endtask

    task automatic test_reset();
        mode = 0; salt = 8'($urandom);
        tick(1'b1); tick(1'b1); tick(1'b1);
        do_reset();
        #1;
        checks++;
        if (obs !== exp_bus) begin
            errors++; $display("FAIL reset_state got=%h want=%h", obs, exp_bus);
        end
        checks++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || v_sync !== 1'b1 || address !== 20'd0) begin
            errors++; $display("FAIL reset_literals got hs=%b vs=%b v_sync=%b addr=%h want 1 1 1 00000",
                               vga_hs, vga_vs, v_sync, address);
        end
    endtask

    task automatic test_free_run();
        int   fs_cnt = 0;
        int   last_fall = -1;
        logic prev_hs = 1'b1;
        mode = 0; salt = 8'($urandom);
        do_reset();
        for (int c = 0; c < 8000 && n < 2 * FRAME + 5; c++) begin
            tick($urandom_range(0, 2) == 0);
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL free_run n=%0d got=%h want=%h", n, obs, exp_bus);
            end
            if (frame_start) fs_cnt++;
            if (prev_hs && !vga_hs) begin
                if (last_fall >= 0) begin
                    checks++;
                    if (n - last_fall != HT) begin
                        errors++; $display("FAIL hs_period got=%0d want=%0d", n - last_fall, HT);
                    end
                end
                last_fall = n;
            end
            prev_hs = vga_hs;
        end
        checks++;
        if (n < 2 * FRAME + 5) begin
            errors++; $display("FAIL free_run_timeout got=%0d want=%0d ticks", n, 2 * FRAME + 5);
        end
        checks++;
        if (fs_cnt != 2) begin
            errors++; $display("FAIL frame_start_count got=%0d want=2", fs_cnt);
        end
    endtask

    task automatic test_pixel_path();
        mode = 2;
        do_reset();
        repeat (7) tick(1'b1);
        checks++;
        if (obs !== exp_bus) begin
            errors++; $display("FAIL pixel_x5 got=%h want=%h", obs, exp_bus);
        end
        checks++;
        if (vga_r !== 4'h0 || vga_g !== 4'h2 || vga_b !== 4'h5 || active !== 1'b1) begin
            errors++; $display("FAIL pixel_x5_rgb got r=%h g=%h b=%h act=%b want 0 2 5 1",
                               vga_r, vga_g, vga_b, active);
        end
        while (n < HA + PD + 1) tick(1'b1);
        checks++;
        if (vga_r !== 4'h0 || vga_g !== 4'h0 || vga_b !== 4'h0 || active !== 1'b0) begin
            errors++; $display("FAIL pixel_blank got r=%h g=%h b=%h act=%b want 0 0 0 0",
                               vga_r, vga_g, vga_b, active);
        end
    endtask

    task automatic test_hold();
        mode = 0; salt = 8'($urandom);
        do_reset();
        repeat (10) tick(1'b1);
        for (int c = 0; c < 100; c++) begin
            tick(1'b0);
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL hold c=%0d got=%h want=%h", c, obs, exp_bus);
            end
        end
        tick(1'b1);
        checks++;
        if (address !== 20'd11 || obs !== exp_bus) begin
            errors++; $display("FAIL hold_resume got=%h want=%h", obs, exp_bus);
        end
    endtask

    task automatic test_reset_mid_line();
        int c;
        mode = 0; salt = 8'($urandom);
        do_reset();
        repeat (HA + HF + 3) tick(1'b1);
        checks++;
        if (vga_hs !== 1'b0) begin
            errors++; $display("FAIL hs_in_pulse got=%b want=0", vga_hs);
        end
        #2;
        rst_n = 1'b0;
        pixel_en = 1'b0;
        n = 0;
        fs_exp = 1'b0;
        #1;
        compute_expected();
        checks++;
        if (obs !== exp_bus || address !== 20'd0) begin
            errors++; $display("FAIL async_reset got=%h want=%h", obs, exp_bus);
        end
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (vga_hs !== 1'b0 && c < 100) begin
            tick(1'b1);
            c++;
        end
        checks++;
        if (n != HA + HF + PD + 1) begin
            errors++; $display("FAIL first_hs_fall got=%0d want=%0d ticks", n, HA + HF + PD + 1);
        end
    endtask

    task automatic test_const_colour();
        int act_seen = 0;
        mode = 1;
        do_reset();
        for (int c = 0; c < 4000 && n < FRAME + 3; c++) begin
            tick($urandom_range(0, 1) == 0);
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL const_colour n=%0d got=%h want=%h", n, obs, exp_bus);
            end
            if (active) act_seen++;
        end
        checks++;
        if (act_seen < HA * VA) begin
            errors++; $display("FAIL const_active_count got=%0d want>=%0d", act_seen, HA * VA);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        mode = 0; salt = 8'($urandom);
        test_mode = 1'b1;
        do_reset();
        repeat (PD + 2) tick(1'b1);
        checks++;
        if (vga_r !== 4'hF || vga_g !== 4'hF || vga_b !== 4'hF) begin
            errors++; $display("FAIL bar0 got r=%h g=%h b=%h want F F F", vga_r, vga_g, vga_b);
        end
        for (int c = 0; c < 3 * HT; c++) begin
            tick(1'b1);
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL pattern n=%0d got=%h want=%h", n, obs, exp_bus);
            end
        end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_pixel_path();
        test_hold();
        test_reset_mid_line();
        test_const_colour();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
